// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Enable and flush bundles are packed so they can be compared and counted as vectors.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_WAIT = 2'd1
    } ctrl_state_e;

    // Field order runs front to back of the pipeline; pc is the MSB.
    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } pipe_en_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
    } pipe_flush_t;

    localparam pipe_en_t EN_ALL  = '{pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};
    localparam pipe_en_t EN_NONE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0};

    // Front of pipe frozen while EX is busy; the back drains behind a bubble.
    localparam pipe_en_t EN_HOLD_FRONT = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b1, memwb: 1'b1};

    // Load-use: hold PC and IF/ID, and let ID/EX take a NOP.
    localparam pipe_en_t EN_LOAD_USE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};

    localparam pipe_flush_t FLUSH_NONE = '{ifid: 1'b0, idex: 1'b0, exmem: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational compare of ID-stage sources against a producer destination.
// A destination of x0 never matches, since x0 is hard-wired and cannot create a dependency.
module load_use_detect #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]             src_used,
    input  logic [ADDR_W-1:0]              dst_addr,
    input  logic                           dst_wen,
    output logic                           hazard
);

    logic               dst_live;
    logic [NUM_SRC-1:0] src_match;

    assign dst_live = dst_wen && (dst_addr != '0);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_match[gi] = dst_live && src_used[gi] && (src_addr[gi] == dst_addr);
    end

    assign hazard = |src_match;

endmodule

// File: rtl/pipe_hazard_controller.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use, multi-cycle mul/div,
// data-memory wait and EX redirects, with stall/flush performance counters.
module pipe_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int REG_ADDR_W    = 5,
    parameter int CNT_W         = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_rd_wen,
    input  logic                  i_ex_is_load,
    input  logic                  i_ex_is_muldiv,
    input  logic                  i_ex_redirect,
    input  logic                  i_dmem_req,
    input  logic                  i_dmem_ack,
    output logic                  o_pc_en,
    output logic                  o_ifid_en,
    output logic                  o_idex_en,
    output logic                  o_exmem_en,
    output logic                  o_memwb_en,
    output logic                  o_ifid_flush,
    output logic                  o_idex_flush,
    output logic                  o_exmem_flush,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam int CNT_BITS = $clog2(MULDIV_CYCLES) + 1;

    ctrl_state_e         state_reg, state_next;
    logic [CNT_BITS-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0]    stall_cnt_reg, flush_cnt_reg;

    pipe_en_t    en;
    pipe_flush_t flush;
    logic        mem_stall;
    logic        src_hazard;
    logic        load_use;

    load_use_detect #(
        .ADDR_W  (REG_ADDR_W),
        .NUM_SRC (2)
    ) u_load_use_detect (
        .src_addr ({i_id_rs2, i_id_rs1}),
        .src_used ({i_id_rs2_used, i_id_rs1_used}),
        .dst_addr (i_ex_rd),
        .dst_wen  (i_ex_rd_wen),
        .hazard   (src_hazard)
    );

    assign mem_stall = i_dmem_req && !i_dmem_ack;
    assign load_use  = i_ex_is_load && src_hazard;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        en         = EN_ALL;
        flush      = FLUSH_NONE;

        if (i_reset) begin
            en = EN_NONE;
        end else if (mem_stall) begin
            // Whole pipe frozen; the mul/div countdown must not advance either.
            en = EN_NONE;
        end else if (state_reg == MULDIV_WAIT) begin
            if (cnt_reg > CNT_BITS'(1)) begin
                en          = EN_HOLD_FRONT;
                flush.exmem = 1'b1;
                cnt_next    = cnt_reg - 1'b1;
            end else begin
                // Release cycle: the result moves into EX/MEM with every bank enabled.
                state_next = RUN;
            end
        end else if (i_ex_is_muldiv) begin
            en          = EN_HOLD_FRONT;
            flush.exmem = 1'b1;
            cnt_next    = CNT_BITS'(MULDIV_CYCLES - 1);
            state_next  = MULDIV_WAIT;
        end else if (i_ex_redirect) begin
            // Squashing ID also removes the consumer of any load-use hazard.
            flush.ifid = 1'b1;
            flush.idex = 1'b1;
        end else if (load_use) begin
            en         = EN_LOAD_USE;
            flush.idex = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (!en.pc) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (|flush) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign o_pc_en       = en.pc;
    assign o_ifid_en     = en.ifid;
    assign o_idex_en     = en.idex;
    assign o_exmem_en    = en.exmem;
    assign o_memwb_en    = en.memwb;
    assign o_ifid_flush  = flush.ifid;
    assign o_idex_flush  = flush.idex;
    assign o_exmem_flush = flush.exmem;
    assign o_busy        = !i_reset && (state_reg == MULDIV_WAIT);
    assign o_stall_cnt   = stall_cnt_reg;
    assign o_flush_cnt   = flush_cnt_reg;

    // A mul/div never resolves a branch, so both flags together means upstream decode is broken.
    a_no_redirect_muldiv : assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_ex_redirect && i_ex_is_muldiv));

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Bench for pipe_hazard_controller: vector table, hand-written multi-cycle sequences,
// and random traffic compared against a cycle-level model of the hazard rules.
module tb_pipe_hazard_controller;

    localparam int MD = 4;

    logic        i_clk;
    logic        i_reset;
    logic [4:0]  i_id_rs1, i_id_rs2, i_ex_rd;
    logic        i_id_rs1_used, i_id_rs2_used, i_ex_rd_wen, i_ex_is_load;
    logic        i_ex_is_muldiv, i_ex_redirect, i_dmem_req, i_dmem_ack;
    logic        o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
    logic        o_ifid_flush, o_idex_flush, o_exmem_flush, o_busy;
    logic [31:0] o_stall_cnt, o_flush_cnt;

    pipe_hazard_controller #(
        .MULDIV_CYCLES (MD),
        .REG_ADDR_W    (5),
        .CNT_W         (32)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_id_rs1       (i_id_rs1),
        .i_id_rs2       (i_id_rs2),
        .i_id_rs1_used  (i_id_rs1_used),
        .i_id_rs2_used  (i_id_rs2_used),
        .i_ex_rd        (i_ex_rd),
        .i_ex_rd_wen    (i_ex_rd_wen),
        .i_ex_is_load   (i_ex_is_load),
        .i_ex_is_muldiv (i_ex_is_muldiv),
        .i_ex_redirect  (i_ex_redirect),
        .i_dmem_req     (i_dmem_req),
        .i_dmem_ack     (i_dmem_ack),
        .o_pc_en        (o_pc_en),
        .o_ifid_en      (o_ifid_en),
        .o_idex_en      (o_idex_en),
        .o_exmem_en     (o_exmem_en),
        .o_memwb_en     (o_memwb_en),
        .o_ifid_flush   (o_ifid_flush),
        .o_idex_flush   (o_idex_flush),
        .o_exmem_flush  (o_exmem_flush),
        .o_busy         (o_busy),
        .o_stall_cnt    (o_stall_cnt),
        .o_flush_cnt    (o_flush_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       reset;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] ex_rd;
        logic       rd_wen;
        logic       is_load;
        logic       is_muldiv;
        logic       redirect;
        logic       dmem_req;
        logic       dmem_ack;
    } stim_t;

    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
    typedef struct packed {
        stim_t      s;
        logic [4:0] en;
        logic [2:0] fl;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model state: EX cycles left for the current mul/div after this one (0 = EX free).
    int          md_left = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    vec_t tbl [12];

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic wen, input logic ld, input logic md,
                                 input logic redir, input logic req, input logic ack);
        stim_t s;
        s = '0;
        s.rs1 = rs1; s.rs2 = rs2; s.rs1_used = u1; s.rs2_used = u2;
        s.ex_rd = rd; s.rd_wen = wen; s.is_load = ld; s.is_muldiv = md;
        s.redirect = redir; s.dmem_req = req; s.dmem_ack = ack;
        return s;
    endfunction

    function automatic stim_t rst_s();
        stim_t s;
        s = '0;
        s.reset = 1'b1;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_load_use(input stim_t s);
        return s.is_load && s.rd_wen && (s.ex_rd != 5'd0) &&
               ((s.rs1_used && s.rs1 == s.ex_rd) || (s.rs2_used && s.rs2 == s.ex_rd));
    endfunction

    function automatic void model_out(input stim_t s, output logic [4:0] en,
                                      output logic [2:0] fl, output logic busy);
        en   = 5'b11111;
        fl   = 3'b000;
        busy = !s.reset && (md_left > 0);
        if (s.reset || (s.dmem_req && !s.dmem_ack)) begin
            en = 5'b00000;
        end else if (md_left == 1) begin
            en = 5'b11111;
        end else if (md_left > 1 || s.is_muldiv) begin
            en = 5'b00011;
            fl = 3'b001;
        end else if (s.redirect) begin
            fl = 3'b110;
        end else if (model_load_use(s)) begin
            en = 5'b00111;
            fl = 3'b010;
        end
    endfunction

    function automatic void model_step(input stim_t s, input logic [4:0] en, input logic [2:0] fl);
        if (s.reset) begin
            md_left = 0;
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!en[4]) m_stall = m_stall + 1;
            if (fl != 3'b000) m_flush = m_flush + 1;
            if (!(s.dmem_req && !s.dmem_ack)) begin
                if (md_left > 0) md_left = md_left - 1;
                else if (s.is_muldiv) md_left = MD - 1;
            end
        end
    endfunction

    task automatic apply(input stim_t s);
        i_reset = s.reset; i_id_rs1 = s.rs1; i_id_rs2 = s.rs2;
        i_id_rs1_used = s.rs1_used; i_id_rs2_used = s.rs2_used;
        i_ex_rd = s.ex_rd; i_ex_rd_wen = s.rd_wen; i_ex_is_load = s.is_load;
        i_ex_is_muldiv = s.is_muldiv; i_ex_redirect = s.redirect;
        i_dmem_req = s.dmem_req; i_dmem_ack = s.dmem_ack;
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    // With hand=1 the outputs are compared against the supplied constants instead of the model.
    task automatic cycle(input stim_t s, input bit hand, input logic [4:0] x_en,
                         input logic [2:0] x_fl, input logic x_busy, input string tag);
        logic [4:0] m_en, e_en;
        logic [2:0] m_fl, e_fl;
        logic       m_busy, e_busy;
        apply(s);
        model_out(s, m_en, m_fl, m_busy);
        e_en   = hand ? x_en : m_en;
        e_fl   = hand ? x_fl : m_fl;
        e_busy = hand ? x_busy : m_busy;
        @(negedge i_clk);
        chk({tag, " en"}, 32'({o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en}), 32'(e_en));
        chk({tag, " flush"}, 32'({o_ifid_flush, o_idex_flush, o_exmem_flush}), 32'(e_fl));
        chk({tag, " busy"}, 32'(o_busy), 32'(e_busy));
        chk({tag, " stall_cnt"}, o_stall_cnt, m_stall);
        chk({tag, " flush_cnt"}, o_flush_cnt, m_flush);
        @(posedge i_clk);
        model_step(s, m_en, m_fl);
        #1;
    endtask

    task automatic cnt_const(input string tag, input logic [31:0] es, input logic [31:0] ef);
        chk({tag, " stall_cnt"}, o_stall_cnt, es);
        chk({tag, " flush_cnt"}, o_flush_cnt, ef);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t idle, ldu, s;
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ldu  = mk(5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        tbl[0]  = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0, 0), 5'b11111, 3'b000};
        tbl[1]  = '{ldu,                                         5'b00111, 3'b010};
        tbl[2]  = '{mk(5'd1, 5'd7, 1, 1, 5'd7, 1, 1, 0, 0, 0, 0), 5'b00111, 3'b010};
        tbl[3]  = '{mk(5'd7, 5'd2, 0, 1, 5'd7, 1, 1, 0, 0, 0, 0), 5'b11111, 3'b000};
        tbl[4]  = '{mk(5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, 0), 5'b11111, 3'b000};
        tbl[5]  = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 0, 1, 0, 0, 0, 0), 5'b11111, 3'b000};
        tbl[6]  = '{mk(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 0, 0), 5'b11111, 3'b000};
        tbl[7]  = '{mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, 0, 0), 5'b11111, 3'b110};
        tbl[8]  = '{mk(5'd5, 5'd9, 1, 1, 5'd5, 1, 1, 0, 1, 0, 0), 5'b11111, 3'b110};
        tbl[9]  = '{mk(5'd5, 5'd9, 1, 1, 5'd5, 1, 1, 0, 0, 1, 0), 5'b00000, 3'b000};
        tbl[10] = '{mk(5'd5, 5'd9, 1, 1, 5'd5, 1, 1, 0, 0, 1, 1), 5'b00111, 3'b010};
        tbl[11] = '{mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, 1, 0), 5'b00000, 3'b000};

        // Bring the DUT out of its unknown power-up state before any comparison.
        apply(rst_s());
        @(posedge i_clk);
        #1;

        cycle(rst_s(), 1, 5'b00000, 3'b000, 1'b0, "reset");
        cycle(idle, 1, 5'b11111, 3'b000, 1'b0, "post_reset");
        cnt_const("post_reset", 32'd0, 32'd0);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].s, 1, tbl[i].en, tbl[i].fl, 1'b0, $sformatf("vec%0d", i));
        end

        // Load-use: exactly one bubble.
        cycle(rst_s(), 1, 5'b00000, 3'b000, 1'b0, "lu_rst");
        cycle(ldu, 1, 5'b00111, 3'b010, 1'b0, "lu_bubble");
        cycle(idle, 1, 5'b11111, 3'b000, 1'b0, "lu_after");
        cnt_const("lu", 32'd1, 32'd1);

        // Mul/div occupies EX for MD cycles; the held muldiv flag must not re-trigger.
        s = idle;
        s.is_muldiv = 1'b1;
        cycle(rst_s(), 1, 5'b00000, 3'b000, 1'b0, "md_rst");
        cycle(s, 1, 5'b00011, 3'b001, 1'b0, "md_T0");
        cycle(s, 1, 5'b00011, 3'b001, 1'b1, "md_T1");
        cycle(s, 1, 5'b00011, 3'b001, 1'b1, "md_T2");
        cycle(s, 1, 5'b11111, 3'b000, 1'b1, "md_T3");
        cycle(idle, 1, 5'b11111, 3'b000, 1'b0, "md_T4");
        cnt_const("md", 32'd3, 32'd3);

        // Memory wait in the middle of a mul/div freezes the countdown.
        cycle(rst_s(), 1, 5'b00000, 3'b000, 1'b0, "mdm_rst");
        cycle(s, 1, 5'b00011, 3'b001, 1'b0, "mdm_T0");
        s.dmem_req = 1'b1;
        cycle(s, 1, 5'b00000, 3'b000, 1'b1, "mdm_T1");
        cycle(s, 1, 5'b00000, 3'b000, 1'b1, "mdm_T2");
        s.dmem_ack = 1'b1;
        cycle(s, 1, 5'b00011, 3'b001, 1'b1, "mdm_T3");
        s.dmem_req = 1'b0;
        s.dmem_ack = 1'b0;
        cycle(s, 1, 5'b00011, 3'b001, 1'b1, "mdm_T4");
        cycle(s, 1, 5'b11111, 3'b000, 1'b1, "mdm_T5");
        cycle(idle, 1, 5'b11111, 3'b000, 1'b0, "mdm_T6");
        cnt_const("mdm", 32'd5, 32'd3);

        // Redirect masks a coincident load-use.
        cycle(rst_s(), 1, 5'b00000, 3'b000, 1'b0, "rdlu_rst");
        s = ldu;
        s.redirect = 1'b1;
        cycle(s, 1, 5'b11111, 3'b110, 1'b0, "rdlu");
        cnt_const("rdlu", 32'd0, 32'd1);

        // Reset in the middle of MULDIV_WAIT.
        s = idle;
        s.is_muldiv = 1'b1;
        cycle(rst_s(), 1, 5'b00000, 3'b000, 1'b0, "mdr_rst");
        cycle(s, 1, 5'b00011, 3'b001, 1'b0, "mdr_T0");
        cycle(s, 1, 5'b00011, 3'b001, 1'b1, "mdr_T1");
        s.reset = 1'b1;
        cycle(s, 1, 5'b00000, 3'b000, 1'b0, "mdr_reset");
        cycle(idle, 1, 5'b11111, 3'b000, 1'b0, "mdr_after");
        cnt_const("mdr", 32'd0, 32'd0);

        // Random traffic against the model; small register range to provoke matches.
        for (int n = 0; n < 2000; n++) begin
            s = '0;
            s.reset     = ($urandom_range(0, 99) == 0);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.rs1_used  = 1'($urandom_range(0, 1));
            s.rs2_used  = 1'($urandom_range(0, 1));
            s.ex_rd     = 5'($urandom_range(0, 3));
            s.rd_wen    = ($urandom_range(0, 3) != 0);
            s.is_load   = 1'($urandom_range(0, 1));
            s.is_muldiv = ($urandom_range(0, 11) == 0);
            s.redirect  = !s.is_muldiv && ($urandom_range(0, 7) == 0);
            s.dmem_req  = ($urandom_range(0, 3) == 0);
            s.dmem_ack  = 1'($urandom_range(0, 1));
            cycle(s, 0, 5'b0, 3'b0, 1'b0, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
